rtc_bus_arbiter: RTL and testbench

- Shares the single RTC register-access engine between three requesters: init sequencer (0), user-edit write machine (1) and periodic time/date reader (2).
- Arbitrates round-robin, one register transaction at a time; presents address, data and direction to the engine; holds the start level until the engine's finish strobe; returns read data and a per-requester ack.
- A watchdog aborts any transaction the engine never finishes.

---
 rtl/rtc_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - round-robin arbiter sharing one RTC register-access engine between three requesters
module rtc_bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     wr,
    input  logic [8*NREQ-1:0]   addr_in,
    input  logic [8*NREQ-1:0]   wdata_in,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     err,
    output logic [7:0]          rdata_out,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                bus_start,
    output logic                bus_wr,
    output logic [7:0]          bus_addr,
    output logic [7:0]          bus_wdata,
    input  logic                bus_fin,
    input  logic [7:0]          bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d, err_q, err_d, grant_q, grant_d;
    logic [7:0]        rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
    logic              busy_q, busy_d, start_q, start_d, wr_q, wr_d;

    logic              win_found;
    logic [1:0]        win_idx;
    logic [1:0]        cand;

    // Scan ptr, ptr+1, ptr+2 (mod NREQ); first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = 2'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = '0;
        grant_d = grant_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        start_d = start_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    wr_d    = wr[win_idx];
                    addr_d  = addr_in[{win_idx, 3'b000} +: 8];
                    wdata_d = wdata_in[{win_idx, 3'b000} +: 8];
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // A finish strobe on the last allowed cycle still counts as success.
                if (bus_fin) begin
                    start_d = 1'b0;
                    rdata_d = wr_q ? 8'h00 : bus_rdata;
                    ack_d   = grant_q;
                    state_d = S_ACK;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    start_d = 1'b0;
                    rdata_d = 8'h00;
                    ack_d   = grant_q;
                    err_d   = grant_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ACK: begin
                rdata_d = 8'h00;
                grant_d = '0;
                addr_d  = 8'h00;
                wdata_d = 8'h00;
                wr_d    = 1'b0;
                busy_d  = 1'b0;
                ptr_d   = grant_q[0] ? 2'd1 : (grant_q[1] ? 2'd2 : 2'd0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            grant_q <= '0;
            rdata_q <= 8'h00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata_out = rdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign bus_start = start_q;
    assign bus_wr    = wr_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - directed vector bench for rtc_bus_arbiter
module tb_rtc_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, wr;
    logic [23:0] addr_in, wdata_in;
    logic [2:0]  ack, err, grant;
    logic [7:0]  rdata_out, bus_addr, bus_wdata, bus_rdata;
    logic        busy, bus_start, bus_wr, bus_fin;

    int tests = 0;
    int fails = 0;

    rtc_bus_arbiter #(.NREQ(3), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .ack(ack), .err(err), .rdata_out(rdata_out), .grant(grant),
        .busy(busy), .bus_start(bus_start), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_fin(bus_fin), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         fin_at;
        int         exp_cyc;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " ack"}, 32'(ack), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " grant"}, 32'(grant), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " bus_start"}, 32'(bus_start), 0);
        chk({tag, " bus_addr"}, 32'(bus_addr), 0);
        chk({tag, " bus_wdata"}, 32'(bus_wdata), 0);
        chk({tag, " bus_wr"}, 32'(bus_wr), 0);
        chk({tag, " rdata_out"}, 32'(rdata_out), 0);
    endtask

    initial begin
        int idx, c, low;
        logic got;
        logic [2:0] rr_exp [4];

        // req wr addr wdata rdata fin_at exp_cyc exp_err exp_rdata
        vecs[0] = '{3'b001, 1'b1, 8'h21, 8'h45, 8'hAA, 5, 5, 1'b0, 8'h00};
        vecs[1] = '{3'b100, 1'b0, 8'h41, 8'h00, 8'h12, 2, 2, 1'b0, 8'h12};
        vecs[2] = '{3'b010, 1'b0, 8'h33, 8'h00, 8'hEE, 0, TO, 1'b1, 8'h00};
        vecs[3] = '{3'b010, 1'b0, 8'h55, 8'h00, 8'h9C, TO, TO, 1'b0, 8'h9C};
        vecs[4] = '{3'b001, 1'b0, 8'h07, 8'h00, 8'h7E, 1, 1, 1'b0, 8'h7E};
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

        reset = 1'b1; req = '0; wr = '0; addr_in = '0; wdata_in = '0;
        bus_fin = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) begin
            idx = vecs[v].req[0] ? 0 : (vecs[v].req[1] ? 1 : 2);
            req = vecs[v].req;
            wr = ~vecs[v].req;
            if (vecs[v].wr) wr = vecs[v].req;
            addr_in = 24'hA5A5A5;
            addr_in[8*idx +: 8] = vecs[v].addr;
            wdata_in = 24'h5A5A5A;
            wdata_in[8*idx +: 8] = vecs[v].wdata;
            @(negedge clk);
            chk($sformatf("v%0d grant", v), 32'(grant), 32'(vecs[v].req));
            chk($sformatf("v%0d bus_start", v), 32'(bus_start), 1);
            chk($sformatf("v%0d bus_addr", v), 32'(bus_addr), 32'(vecs[v].addr));
            chk($sformatf("v%0d bus_wdata", v), 32'(bus_wdata), 32'(vecs[v].wdata));
            chk($sformatf("v%0d bus_wr", v), 32'(bus_wr), 32'(vecs[v].wr));
            req = '0; addr_in = ~addr_in; wdata_in = ~wdata_in;
            c = 0; got = 1'b0;
            while (!got && c < 40) begin
                c++;
                bus_fin = (c == vecs[v].fin_at);
                bus_rdata = vecs[v].rdata;
                @(negedge clk);
                bus_fin = 1'b0;
                if (ack != 3'b000) got = 1'b1;
            end
            chk($sformatf("v%0d ack_cycle", v), 32'(c), 32'(vecs[v].exp_cyc));
            chk($sformatf("v%0d ack", v), 32'(ack), 32'(vecs[v].req));
            chk($sformatf("v%0d err", v), 32'(err), vecs[v].exp_err ? 32'(vecs[v].req) : 0);
            chk($sformatf("v%0d rdata_out", v), 32'(rdata_out), 32'(vecs[v].exp_rdata));
            chk($sformatf("v%0d start_low", v), 32'(bus_start), 0);
            chk($sformatf("v%0d addr_held", v), 32'(bus_addr), 32'(vecs[v].addr));
            chk($sformatf("v%0d busy_ack", v), 32'(busy), 1);
            @(negedge clk);
            chk_idle_outputs($sformatf("v%0d after", v));
        end

        // Spurious finish strobe while idle must be ignored.
        bus_fin = 1'b1; bus_rdata = 8'h5A;
        @(negedge clk);
        bus_fin = 1'b0;
        @(negedge clk);
        chk_idle_outputs("spurious");

        // Round-robin with all three requesting, ptr restarted by reset.
        reset = 1'b1; req = 3'b111; wr = 3'b000; addr_in = 24'h030201; wdata_in = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            low = 0;
            while (bus_start == 1'b0 && low < 10) begin
                low++;
                @(negedge clk);
            end
            chk($sformatf("rr%0d grant", k), 32'(grant), 32'(rr_exp[k]));
            if (k > 0) chk($sformatf("rr%0d gap", k), 32'(low >= 2), 1);
            for (int c2 = 1; c2 <= 3; c2++) begin
                bus_fin = (c2 == 3); bus_rdata = 8'h10 + 8'(k);
                @(negedge clk);
                bus_fin = 1'b0;
            end
            chk($sformatf("rr%0d ack", k), 32'(ack), 32'(rr_exp[k]));
            chk($sformatf("rr%0d rdata", k), 32'(rdata_out), 32'(8'h10 + 8'(k)));
        end
        req = 3'b000;
        repeat (2) @(negedge clk);

        // Reset in the middle of a transaction, then ptr must restart at 0.
        req = 3'b010;
        @(negedge clk);
        chk("mid grant", 32'(grant), 32'(3'b010));
        @(negedge clk);
        reset = 1'b1; req = 3'b111;
        @(negedge clk);
        chk_idle_outputs("mid reset");
        reset = 1'b0;
        @(negedge clk);
        chk("post reset grant", 32'(grant), 32'(3'b001));
        chk("post reset start", 32'(bus_start), 1);
        req = 3'b000;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
